// File: rtl/rst_req_ctrl.sv
// Soft-reset request controller: register-driven or watchdog-driven reset requests with delay, hold and cool-down.
// Optional macro RST_REQ_KEY_EN requires key 16'h5A5A in req_wdata[31:16] for CTRL requests.
module rst_req_ctrl #(
    parameter int unsigned DELAY_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    input  logic        wdt_expire,
    output logic [1:0]  cpu_pad_soft_rst,
    output logic        rst_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_ASSERT = 2'd2;
    localparam logic [1:0] S_COOL   = 2'd3;

    localparam logic [7:0] DELAY_LOAD = 8'(DELAY_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] COOL_LOAD  = 8'd1;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CAUSE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sys_q, sys_d;
    logic        err_q, err_d;
    logic [2:0]  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr, rd, ctrl_wr, ctrl_req, key_ok;
    logic [2:0]  cause_set, cause_clr;
    logic        busy;
    logic        unused_wdata;

`ifdef RST_REQ_KEY_EN
    assign key_ok = (req_wdata[31:16] == 16'h5A5A);
`else
    assign key_ok = 1'b1;
`endif

    assign unused_wdata = ^req_wdata[31:3];

    assign wr       = req_valid & req_write;
    assign rd       = req_valid & ~req_write;
    assign ctrl_wr  = wr & (req_addr == A_CTRL);
    assign ctrl_req = ctrl_wr & (req_wdata[1:0] != 2'b00);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sys_d     = sys_q;
        cause_set = '0;
        // Watchdog in IDLE/DELAY outranks any software request in the same cycle.
        case (state_q)
            S_IDLE: begin
                if (wdt_expire) begin
                    state_d   = S_ASSERT;
                    cnt_d     = HOLD_LOAD;
                    sys_d     = 1'b1;
                    cause_set = 3'b100;
                end else if (ctrl_req && key_ok) begin
                    state_d = S_DELAY;
                    cnt_d   = DELAY_LOAD;
                    sys_d   = req_wdata[1];
                end
            end
            S_DELAY: begin
                if (wdt_expire) begin
                    state_d   = S_ASSERT;
                    cnt_d     = HOLD_LOAD;
                    sys_d     = 1'b1;
                    cause_set = 3'b100;
                end else if (cnt_q == '0) begin
                    state_d   = S_ASSERT;
                    cnt_d     = HOLD_LOAD;
                    cause_set = sys_q ? 3'b010 : 3'b001;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = S_COOL;
                    cnt_d   = COOL_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (ctrl_req) begin
            if (busy || !key_ok) begin
                err_d = 1'b1;
            end
        end else if (ctrl_wr) begin
            err_d = 1'b0;
        end
    end

    // Set is OR-ed after the clear mask so a same-cycle set survives the clear.
    assign cause_clr = (wr && req_addr == A_CAUSE) ? req_wdata[2:0] : 3'b000;
    assign cause_d   = (cause_q & ~cause_clr) | cause_set;

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (req_addr)
                A_STATUS: rdata_d = {27'b0, err_q, state_q, busy};
                A_CAUSE:  rdata_d = {29'b0, cause_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sys_q   <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sys_q   <= sys_d;
            err_q   <= err_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_pad_soft_rst = (state_q == S_ASSERT) ? (sys_q ? 2'b10 : 2'b01) : 2'b00;
    assign rst_busy         = busy;
    assign rsp_rdata        = rdata_q;

endmodule
